onehot_arb_mux: RTL and testbench

- Parametrised successor of the team's combinational one-hot 6:1 mux.
- Arbitrates among N valid/ready source channels of W bits each and generates the one-hot select internally, either round-robin or fixed-priority.
- The selected word passes through the same AND-OR one-hot mux structure, then into a single registered output slot with valid/ready handshake.
- Sits between multiple producer stages and one shared consumer.

---
 rtl/onehot_arb_mux.sv | 111 +++++++++++
 tb/tb_onehot_arb_mux.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_arb_mux.sv
// N-channel valid/ready arbiter feeding an AND-OR one-hot mux and a single
// registered output slot. Round-robin or fixed-priority grant selected by MODE.
module onehot_arb_mux #(
   parameter int N    = 6,
   parameter int W    = 3,
   parameter int MODE = 0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N*W-1:0] in_data,
   input  logic [N-1:0]   in_valid,
   output logic [N-1:0]   in_ready,
   output logic [W-1:0]   out_data,
   output logic [N-1:0]   out_grant,
   output logic           out_valid,
   input  logic           out_ready
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   // Isolate the lowest set bit; zero in gives zero out.
   function automatic logic [N-1:0] f_lowest(input logic [N-1:0] v);
      return v & (~v + N'(1));
   endfunction

   // Bits at or above the round-robin pointer.
   function automatic logic [N-1:0] f_ptr_mask(input logic [PW-1:0] p);
      logic [N-1:0] m;
      m = '0;
      for (int i = 0; i < N; i++) begin
         m[i] = (i >= int'(p));
      end
      return m;
   endfunction

   function automatic logic [PW-1:0] f_index(input logic [N-1:0] oh);
      logic [PW-1:0] idx;
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (oh[i]) idx = idx | PW'(i);
      end
      return idx;
   endfunction

   logic [PW-1:0] r_ptr;
   logic [N-1:0]  w_masked_p0;
   logic [N-1:0]  w_grant_p0;
   logic [W-1:0]  w_sel_data_p0;
   logic [PW-1:0] w_grant_idx_p0;
   logic          w_can_load;
   logic          w_load;

   logic [W-1:0]  r_data_p1;
   logic [N-1:0]  r_grant_p1;
   logic          r_vld_p1;

   // ---- stage p0: grant, one-hot mux, handshake ----
   assign w_masked_p0 = in_valid & f_ptr_mask(r_ptr);

   always_comb begin
      w_grant_p0 = '0;
      if (MODE == 1) begin
         w_grant_p0 = f_lowest(in_valid);
      end else if (|w_masked_p0) begin
         w_grant_p0 = f_lowest(w_masked_p0);
      end else begin
         // Nothing at or above the pointer: wrap to the bottom of the ring.
         w_grant_p0 = f_lowest(in_valid);
      end
   end

   always_comb begin
      w_sel_data_p0 = '0;
      for (int i = 0; i < N; i++) begin
         w_sel_data_p0 = w_sel_data_p0 | (in_data[i*W +: W] & {W{w_grant_p0[i]}});
      end
   end

   assign w_grant_idx_p0 = f_index(w_grant_p0);
   assign w_can_load     = ~r_vld_p1 | out_ready;
   assign w_load         = (|w_grant_p0) & w_can_load;
   assign in_ready       = w_grant_p0 & {N{w_can_load}};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if ((MODE == 0) && w_load) begin
         r_ptr <= (w_grant_idx_p0 == PW'(N - 1)) ? '0 : w_grant_idx_p0 + PW'(1);
      end
   end

   // ---- stage p1: registered output slot ----
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_p1   <= 1'b0;
         r_data_p1  <= '0;
         r_grant_p1 <= '0;
      end else if (w_load) begin
         r_vld_p1   <= 1'b1;
         r_data_p1  <= w_sel_data_p0;
         r_grant_p1 <= w_grant_p0;
      end else if (out_ready) begin
         r_vld_p1   <= 1'b0;
      end
   end

   assign out_data  = r_data_p1;
   assign out_grant = r_grant_p1;
   assign out_valid = r_vld_p1;

endmodule

// File: tb/tb_onehot_arb_mux.sv
// Bench for onehot_arb_mux: round-robin and fixed-priority instances share
// stimulus; a reference model pushes expected words, popped on each drain.
module tb_onehot_arb_mux;
   localparam int N = 6;
   localparam int W = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid;
   logic           out_ready;

   logic [N-1:0] rdy0, og0, rdy1, og1;
   logic [W-1:0] od0, od1;
   logic         ov0, ov1;

   int vectors     = 0;
   int miscompares = 0;

   int               m_ptr [2];
   logic             m_ov  [2];
   logic [W+N-1:0]   sbq0[$];
   logic [W+N-1:0]   sbq1[$];

   always #5 clk = ~clk;

   onehot_arb_mux #(.N(N), .W(W), .MODE(0)) u_rr (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy0), .out_data(od0), .out_grant(og0),
      .out_valid(ov0), .out_ready(out_ready));

   onehot_arb_mux #(.N(N), .W(W), .MODE(1)) u_fp (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy1), .out_data(od1), .out_grant(og1),
      .out_valid(ov1), .out_ready(out_ready));

   // Reference arbitration: walk the ring starting at ptr (or at 0 for priority).
   function automatic logic [N-1:0] model_grant(input int mode, input int ptr,
                                                input logic [N-1:0] v, output int idx);
      idx = 0;
      for (int k = 0; k < N; k++) begin
         int c;
         c = (mode == 1) ? k : (ptr + k) % N;
         if (v[c]) begin
            idx = c;
            return N'(1) << c;
         end
      end
      return '0;
   endfunction

   // One clock: check handshake and drains at negedge, advance the model at posedge.
   task automatic tick();
      logic [N-1:0]   g_s [2];
      int             idx_s [2];
      logic           can_s [2];
      logic           rst_s, ordy_s;
      logic [N*W-1:0] data_s;
      logic [N-1:0]   rdy, og, exp_rdy;
      logic [W-1:0]   od;
      logic           ov;
      logic [W+N-1:0] e;
      @(negedge clk);
      rst_s  = rst;
      ordy_s = out_ready;
      data_s = in_data;
      for (int d = 0; d < 2; d++) begin
         rdy = (d == 0) ? rdy0 : rdy1;
         og  = (d == 0) ? og0  : og1;
         od  = (d == 0) ? od0  : od1;
         ov  = (d == 0) ? ov0  : ov1;
         g_s[d]   = model_grant(d, m_ptr[d], in_valid, idx_s[d]);
         can_s[d] = !m_ov[d] || out_ready;
         exp_rdy  = can_s[d] ? g_s[d] : {N{1'b0}};
         vectors++;
         if (rdy !== exp_rdy) begin
            miscompares++;
            $display("FAIL in_ready dut%0d: got %b want %b", d, rdy, exp_rdy);
         end
         vectors++;
         if (ov !== m_ov[d]) begin
            miscompares++;
            $display("FAIL out_valid dut%0d: got %b want %b", d, ov, m_ov[d]);
         end
         if (!rst && m_ov[d] && out_ready) begin
            if (d == 0) e = sbq0.pop_front();
            else        e = sbq1.pop_front();
            vectors++;
            if ({od, og} !== e) begin
               miscompares++;
               $display("FAIL drain dut%0d: got data %0d grant %b want data %0d grant %b",
                        d, od, og, e[W+N-1:N], e[N-1:0]);
            end
         end
      end
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         if (rst_s) begin
            m_ov[d]  = 1'b0;
            m_ptr[d] = 0;
            if (d == 0) sbq0.delete();
            else        sbq1.delete();
         end else if (can_s[d] && (g_s[d] != '0)) begin
            if (d == 0) sbq0.push_back({data_s[idx_s[d]*W +: W], g_s[d]});
            else        sbq1.push_back({data_s[idx_s[d]*W +: W], g_s[d]});
            m_ov[d] = 1'b1;
            if (d == 0) m_ptr[d] = (idx_s[d] == N - 1) ? 0 : idx_s[d] + 1;
         end else if (m_ov[d] && ordy_s) begin
            m_ov[d] = 1'b0;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = '0; out_ready = 1'b1; in_data = '0;
      repeat (2) @(posedge clk);
      #1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if ({ov0, od0, og0, rdy0} !== '0) begin
            miscompares++;
            $display("FAIL reset_idle: got v=%b d=%0d g=%b r=%b want all zero", ov0, od0, og0, rdy0);
         end
         vectors++;
         if (ov1 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle_fp: got out_valid %b want 0", ov1);
         end
      end
   endtask

   task automatic test_rotate();
      for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(i + 1);
      in_valid = '1; out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         vectors++;
         if (ov0 !== 1'b1 || od0 !== W'(i % N + 1) || og0 !== (N'(1) << (i % N))) begin
            miscompares++;
            $display("FAIL rotate[%0d]: got v=%b d=%0d g=%b want v=1 d=%0d g=%b",
                     i, ov0, od0, og0, i % N + 1, N'(1) << (i % N));
         end
      end
   endtask

   task automatic test_stall();
      in_valid = 6'b001000; out_ready = 1'b1;
      tick();
      in_valid = '1; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (ov0 !== 1'b1 || od0 !== 3'd4 || og0 !== 6'b001000 || rdy0 !== 6'b0) begin
            miscompares++;
            $display("FAIL stall[%0d]: got v=%b d=%0d g=%b r=%b want v=1 d=4 g=001000 r=000000",
                     i, ov0, od0, og0, rdy0);
         end
      end
      out_ready = 1'b1;
      tick();
      vectors++;
      if (od0 !== 3'd5 || og0 !== 6'b010000) begin
         miscompares++;
         $display("FAIL stall_release: got d=%0d g=%b want d=5 g=010000", od0, og0);
      end
   endtask

   task automatic test_priority();
      in_valid = 6'b101100; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (od1 !== 3'd3 || og1 !== 6'b000100 || rdy1 !== 6'b000100) begin
            miscompares++;
            $display("FAIL priority[%0d]: got d=%0d g=%b r=%b want d=3 g=000100 r=000100",
                     i, od1, og1, rdy1);
         end
      end
   endtask

   task automatic test_sparse();
      in_valid = 6'b001000; out_ready = 1'b1;
      tick();
      in_valid = 6'b000010;
      tick();
      vectors++;
      if (od0 !== 3'd2 || og0 !== 6'b000010) begin
         miscompares++;
         $display("FAIL sparse: got d=%0d g=%b want d=2 g=000010", od0, og0);
      end
      in_valid = 6'b000111;
      tick();
      vectors++;
      if (od0 !== 3'd3 || og0 !== 6'b000100) begin
         miscompares++;
         $display("FAIL sparse_ptr: got d=%0d g=%b want d=3 g=000100", od0, og0);
      end
   endtask

   task automatic test_reset_mid();
      in_valid = 6'b010000; out_ready = 1'b1;
      tick();
      in_valid = '0; out_ready = 1'b0;
      tick();
      vectors++;
      if (ov0 !== 1'b1 || od0 !== 3'd5) begin
         miscompares++;
         $display("FAIL reset_mid_hold: got v=%b d=%0d want v=1 d=5", ov0, od0);
      end
      rst = 1'b1;
      tick();
      vectors++;
      if (ov0 !== 1'b0 || od0 !== 3'd0 || og0 !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_mid_clear: got v=%b d=%0d g=%b want v=0 d=0 g=000000", ov0, od0, og0);
      end
      rst = 1'b0; in_valid = '1; out_ready = 1'b1;
      tick();
      vectors++;
      if (ov0 !== 1'b1 || od0 !== 3'd1 || og0 !== 6'b000001) begin
         miscompares++;
         $display("FAIL reset_mid_restart: got v=%b d=%0d g=%b want v=1 d=1 g=000001", ov0, od0, og0);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 300; i++) begin
         in_valid  = N'($urandom);
         in_data   = (N*W)'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      in_valid = '0; out_ready = 1'b1;
      repeat (2) tick();
      vectors++;
      if (sbq0.size() != 0 || sbq1.size() != 0 || ov0 !== 1'b0 || ov1 !== 1'b0) begin
         miscompares++;
         $display("FAIL drain_empty: got q0=%0d q1=%0d v0=%b v1=%b want all empty",
                  sbq0.size(), sbq1.size(), ov0, ov1);
      end
   endtask

   initial begin
      m_ptr[0] = 0; m_ptr[1] = 0;
      m_ov[0]  = 1'b0; m_ov[1] = 1'b0;
      test_reset();
      test_rotate();
      test_stall();
      test_priority();
      test_sparse();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
